// File: rtl/nios_system_2a_sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : nios_system_2a_sample_packer
// Description : Packs a valid/ready byte stream four-samples-per-word
//               (little-endian) and writes the words through an arbitrated
//               single-port memory interface to a contiguous word range.
//               Optional feature macro: SAMPLE_PACKER_WRAP_EN (address wraps
//               to BASE_ADDR after the last word instead of halting, and a
//               sticky `wrapped` output is added).
// Revision    : 1.0 - initial release
// ============================================================================
module nios_system_2a_sample_packer #(
    parameter int BASE_ADDR   = 0,
    parameter int DEPTH_WORDS = 40000,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [7:0]        snk_data,
    input  logic              snk_valid,
    input  logic              snk_eop,
    output logic              snk_ready,
    output logic              mem_req,
    input  logic              mem_grant,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    output logic [15:0]       words_written,
    output logic              busy,
`ifdef SAMPLE_PACKER_WRAP_EN
    output logic              wrapped,
`endif
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] C_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(BASE_ADDR + DEPTH_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_pack;
    logic [3:0]         r_mask;
    logic [1:0]         r_lane;
    logic [31:0]        r_wbuf;
    logic [3:0]         r_wmask;
    logic               r_wvalid;
    logic [ADDR_W-1:0]  r_addr;
    logic [15:0]        r_words;
    logic               r_overflow;
`ifdef SAMPLE_PACKER_WRAP_EN
    logic               r_wrapped;
`endif

    logic               w_write;
    logic               w_room;
    logic               w_ready;
    logic               w_accept;
    logic               w_complete;
    logic               w_flush_move;
    logic               w_last_wr;
    logic               w_halt;
    logic               w_arm;
    logic [31:0]        w_pack_merged;
    logic [3:0]         w_mask_merged;

    // The word buffer can take a new word when empty or draining this cycle.
    assign w_write      = r_wvalid & mem_grant;
    assign w_room       = ~r_wvalid | mem_grant;
    assign w_ready      = (r_state == S_RUN) & w_room;
    assign w_accept     = snk_valid & w_ready;
    assign w_complete   = w_accept & ((r_lane == 2'd3) | snk_eop);
    assign w_flush_move = (r_state == S_FLUSH) & (r_mask != 4'd0) & w_room;
    assign w_last_wr    = w_write & (r_addr == C_LAST);
    assign w_arm        = start & ((r_state == S_IDLE) | (r_state == S_HALT));
`ifdef SAMPLE_PACKER_WRAP_EN
    assign w_halt       = 1'b0;
`else
    assign w_halt       = w_last_wr;
`endif

    // Current pack register with the incoming byte dropped into its lane.
    always_comb begin
        w_pack_merged = r_pack;
        w_pack_merged[{r_lane, 3'b000} +: 8] = snk_data;
        w_mask_merged = r_mask | (4'b0001 << r_lane);
    end

    // Next-state decode; only the pulse legal for the current state acts.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN: begin
                if (w_halt)     w_state_next = S_HALT;
                else if (stop)  w_state_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (w_halt)     w_state_next = S_HALT;
                else if ((r_mask == 4'd0) && !r_wvalid) w_state_next = S_IDLE;
            end
            S_HALT:  if (start) w_state_next = S_RUN;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Pack register, word buffer, address and status counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pack     <= 32'd0;
            r_mask     <= 4'd0;
            r_lane     <= 2'd0;
            r_wbuf     <= 32'd0;
            r_wmask    <= 4'd0;
            r_wvalid   <= 1'b0;
            r_addr     <= C_BASE;
            r_words    <= 16'd0;
            r_overflow <= 1'b0;
`ifdef SAMPLE_PACKER_WRAP_EN
            r_wrapped  <= 1'b0;
`endif
        end else if (w_arm) begin
            r_pack     <= 32'd0;
            r_mask     <= 4'd0;
            r_lane     <= 2'd0;
            r_wmask    <= 4'd0;
            r_wvalid   <= 1'b0;
            r_addr     <= C_BASE;
            r_words    <= 16'd0;
            r_overflow <= 1'b0;
`ifdef SAMPLE_PACKER_WRAP_EN
            r_wrapped  <= 1'b0;
`endif
        end else begin
            if (w_halt) begin
                // Range exhausted: anything still pending has nowhere to go.
                r_pack   <= 32'd0;
                r_mask   <= 4'd0;
                r_lane   <= 2'd0;
                r_wmask  <= 4'd0;
                r_wvalid <= 1'b0;
            end else begin
                if (w_complete || w_flush_move) begin
                    r_pack <= 32'd0;
                    r_mask <= 4'd0;
                    r_lane <= 2'd0;
                end else if (w_accept) begin
                    r_pack <= w_pack_merged;
                    r_mask <= w_mask_merged;
                    r_lane <= r_lane + 2'd1;
                end

                if (w_complete) begin
                    r_wbuf   <= w_pack_merged;
                    r_wmask  <= w_mask_merged;
                    r_wvalid <= 1'b1;
                end else if (w_flush_move) begin
                    r_wbuf   <= r_pack;
                    r_wmask  <= r_mask;
                    r_wvalid <= 1'b1;
                end else if (w_write) begin
                    r_wmask  <= 4'd0;
                    r_wvalid <= 1'b0;
                end
            end

            if (w_write) begin
`ifdef SAMPLE_PACKER_WRAP_EN
                if (r_addr == C_LAST) begin
                    r_addr    <= C_BASE;
                    r_wrapped <= 1'b1;
                end else begin
                    r_addr    <= r_addr + 1'b1;
                end
`else
                r_addr <= r_addr + 1'b1;
`endif
                if (r_words != 16'hFFFF) r_words <= r_words + 16'd1;
            end

            if ((r_state == S_HALT) && snk_valid) r_overflow <= 1'b1;
        end
    end

    assign snk_ready      = w_ready;
    assign mem_req        = r_wvalid;
    assign mem_chipselect = w_write;
    assign mem_write      = w_write;
    assign mem_address    = r_addr;
    assign mem_byteenable = r_wmask;
    assign mem_writedata  = r_wbuf;
    assign words_written  = r_words;
    assign busy           = (r_state != S_IDLE);
    assign overflow       = r_overflow;
`ifdef SAMPLE_PACKER_WRAP_EN
    assign wrapped        = r_wrapped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nios_system_2a_sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios_system_2a_sample_packer
// Description : Self-checking bench for nios_system_2a_sample_packer with a
//               4-word capture range. Table-driven per-cycle vectors plus
//               hand-written halt/overflow and async-reset sequences.
//               Honours SAMPLE_PACKER_WRAP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios_system_2a_sample_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop;
    logic [7:0]  snk_data;
    logic        snk_valid, snk_eop, snk_ready;
    logic        mem_req, mem_grant, mem_chipselect, mem_write;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [15:0] words_written;
    logic        busy, overflow;
`ifdef SAMPLE_PACKER_WRAP_EN
    logic        wrapped;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nios_system_2a_sample_packer #(
        .BASE_ADDR   (0),
        .DEPTH_WORDS (4),
        .ADDR_W      (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .snk_data       (snk_data),
        .snk_valid      (snk_valid),
        .snk_eop        (snk_eop),
        .snk_ready      (snk_ready),
        .mem_req        (mem_req),
        .mem_grant      (mem_grant),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .words_written  (words_written),
        .busy           (busy),
`ifdef SAMPLE_PACKER_WRAP_EN
        .wrapped        (wrapped),
`endif
        .overflow       (overflow)
    );

    typedef struct {
        logic [7:0]  d;
        logic        v, e, g, st, sp;
        logic        rdy, req, wr, bsy;
        logic [15:0] ad;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [15:0] wc;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic v, input logic e,
                                input logic g, input logic st, input logic sp,
                                input logic rdy, input logic req, input logic wr,
                                input logic bsy, input logic [15:0] ad,
                                input logic [3:0] be, input logic [31:0] wd,
                                input logic [15:0] wc);
        vec_t t;
        t.d = d; t.v = v; t.e = e; t.g = g; t.st = st; t.sp = sp;
        t.rdy = rdy; t.req = req; t.wr = wr; t.bsy = bsy;
        t.ad = ad; t.be = be; t.wd = wd; t.wc = wc;
        return t;
    endfunction

    task automatic drive(input logic [7:0] d, input logic v, input logic e,
                         input logic g, input logic st, input logic sp);
        snk_data = d; snk_valid = v; snk_eop = e; mem_grant = g; start = st; stop = sp;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int          n_wr;
    logic [15:0] wr_addr[8];

    initial begin
        // Vectors: inputs, then expected ready/req/write/busy/addr/be/data/count
        // seen in the same cycle (before the closing edge).
        vecs[0]  = mk(8'h00,0,0,1,1,0, 0,0,0,0, 16'd0, 4'h0, 32'h0,        16'd0);
        vecs[1]  = mk(8'h11,1,0,1,0,0, 1,0,0,1, 16'd0, 4'h0, 32'h0,        16'd0);
        vecs[2]  = mk(8'h22,1,0,1,0,0, 1,0,0,1, 16'd0, 4'h0, 32'h0,        16'd0);
        vecs[3]  = mk(8'h33,1,0,1,0,0, 1,0,0,1, 16'd0, 4'h0, 32'h0,        16'd0);
        vecs[4]  = mk(8'h44,1,0,1,0,0, 1,0,0,1, 16'd0, 4'h0, 32'h0,        16'd0);
        vecs[5]  = mk(8'hAA,1,0,1,0,0, 1,1,1,1, 16'd0, 4'hF, 32'h44332211, 16'd0);
        vecs[6]  = mk(8'hBB,1,1,1,0,0, 1,0,0,1, 16'd1, 4'h0, 32'h0,        16'd1);
        vecs[7]  = mk(8'h00,0,0,1,0,0, 1,1,1,1, 16'd1, 4'h3, 32'h0000BBAA, 16'd1);
        vecs[8]  = mk(8'h00,0,0,1,0,0, 1,0,0,1, 16'd2, 4'h0, 32'h0,        16'd2);
        vecs[9]  = mk(8'h01,1,0,1,0,0, 1,0,0,1, 16'd2, 4'h0, 32'h0,        16'd2);
        vecs[10] = mk(8'h02,1,0,1,0,0, 1,0,0,1, 16'd2, 4'h0, 32'h0,        16'd2);
        vecs[11] = mk(8'h03,1,0,1,0,1, 1,0,0,1, 16'd2, 4'h0, 32'h0,        16'd2);
        vecs[12] = mk(8'h00,0,0,1,0,0, 0,0,0,1, 16'd2, 4'h0, 32'h0,        16'd2);
        vecs[13] = mk(8'h00,0,0,1,0,0, 0,1,1,1, 16'd2, 4'h7, 32'h00030201, 16'd2);
        vecs[14] = mk(8'h00,0,0,1,0,0, 0,0,0,1, 16'd3, 4'h0, 32'h0,        16'd3);
        vecs[15] = mk(8'h00,0,0,1,0,0, 0,0,0,0, 16'd3, 4'h0, 32'h0,        16'd3);
        vecs[16] = mk(8'h00,0,0,1,1,0, 0,0,0,0, 16'd3, 4'h0, 32'h0,        16'd3);
        vecs[17] = mk(8'h01,1,0,0,0,0, 1,0,0,1, 16'd0, 4'h0, 32'h0,        16'd0);
        vecs[18] = mk(8'h02,1,0,0,0,0, 1,0,0,1, 16'd0, 4'h0, 32'h0,        16'd0);
        vecs[19] = mk(8'h03,1,0,0,0,0, 1,0,0,1, 16'd0, 4'h0, 32'h0,        16'd0);
        vecs[20] = mk(8'h04,1,0,0,0,0, 1,0,0,1, 16'd0, 4'h0, 32'h0,        16'd0);
        vecs[21] = mk(8'h05,1,0,0,0,0, 0,1,0,1, 16'd0, 4'hF, 32'h04030201, 16'd0);
        vecs[22] = mk(8'h05,1,0,0,0,0, 0,1,0,1, 16'd0, 4'hF, 32'h04030201, 16'd0);
        vecs[23] = mk(8'h05,1,0,1,0,0, 1,1,1,1, 16'd0, 4'hF, 32'h04030201, 16'd0);
        vecs[24] = mk(8'h00,0,0,1,0,0, 1,0,0,1, 16'd1, 4'h0, 32'h0,        16'd1);

        // Reset state
        reset = 1'b1;
        drive(8'h00, 0, 0, 1, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", snk_ready, 0);
        check("rst_req",   mem_req,   0);
        check("rst_write", mem_write, 0);
        check("rst_cs",    mem_chipselect, 0);
        check("rst_addr",  mem_address, 0);
        check("rst_be",    mem_byteenable, 0);
        check("rst_wd",    mem_writedata, 0);
        check("rst_wc",    words_written, 0);
        check("rst_busy",  busy, 0);
        check("rst_ovf",   overflow, 0);
        next_cycle();
        reset = 1'b0;

        // Table-driven cycles: basic pack, eop partial, stop/flush, grant stall
        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].d, vecs[i].v, vecs[i].e, vecs[i].g, vecs[i].st, vecs[i].sp);
            @(negedge clk);
            check($sformatf("v%0d_ready", i), snk_ready, vecs[i].rdy);
            check($sformatf("v%0d_req",   i), mem_req,   vecs[i].req);
            check($sformatf("v%0d_write", i), mem_write, vecs[i].wr);
            check($sformatf("v%0d_cs",    i), mem_chipselect, vecs[i].wr);
            check($sformatf("v%0d_busy",  i), busy,      vecs[i].bsy);
            check($sformatf("v%0d_addr",  i), mem_address, vecs[i].ad);
            check($sformatf("v%0d_words", i), words_written, vecs[i].wc);
            if (vecs[i].req) begin
                check($sformatf("v%0d_be", i), mem_byteenable, vecs[i].be);
                check($sformatf("v%0d_wd", i), mem_writedata,  vecs[i].wd);
            end
            next_cycle();
        end

        // Return to IDLE: stop flushes the single pending byte.
        drive(8'h00, 0, 0, 1, 0, 1);
        next_cycle();
        drive(8'h00, 0, 0, 1, 0, 0);
        for (int k = 0; k < 20 && busy; k++) next_cycle();
        check("idle_after_stop", busy, 0);

        // Stream 20 bytes into a 4-word range.
        drive(8'h00, 0, 0, 1, 1, 0);
        next_cycle();
        n_wr = 0;
        for (int i = 1; i <= 22; i++) begin
            drive(8'(i), (i <= 20), 0, 1, 0, 0);
            @(negedge clk);
            if (mem_write) begin
                if (n_wr < 8) wr_addr[n_wr] = mem_address;
                n_wr++;
            end
            next_cycle();
        end
        drive(8'h00, 0, 0, 1, 0, 0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) check($sformatf("range_addr%0d", k), wr_addr[k], 16'(k));
`ifdef SAMPLE_PACKER_WRAP_EN
        check("wrap_writes",  n_wr, 5);
        check("wrap_addr4",   wr_addr[4], 0);
        check("wrapped",      wrapped, 1);
        check("wrap_busy",    busy, 1);
        check("wrap_ready",   snk_ready, 1);
`else
        check("halt_writes",  n_wr, 4);
        check("halt_words",   words_written, 4);
        check("halt_busy",    busy, 1);
        check("halt_ready",   snk_ready, 0);
        check("halt_ovf",     overflow, 1);
        check("halt_req",     mem_req, 0);
        // start from HALT clears overflow
        next_cycle();
        drive(8'h00, 0, 0, 1, 1, 0);
        next_cycle();
        drive(8'h00, 0, 0, 1, 0, 0);
        @(negedge clk);
        check("restart_ovf",  overflow, 0);
        check("restart_addr", mem_address, 0);
        check("restart_wc",   words_written, 0);
        check("restart_ready", snk_ready, 1);
`endif
        next_cycle();

        // Async reset with a full word buffer.
        for (int i = 0; i < 4; i++) begin
            drive(8'hC0 + 8'(i), 1, 0, 0, 0, 0);
            next_cycle();
        end
        drive(8'h00, 0, 0, 1, 0, 0);
        #1;
        check("prereset_write", mem_write, 1);
        reset = 1'b1;
        #1;
        check("arst_write", mem_write, 0);
        check("arst_cs",    mem_chipselect, 0);
        check("arst_req",   mem_req, 0);
        check("arst_ready", snk_ready, 0);
        check("arst_be",    mem_byteenable, 0);
        check("arst_wd",    mem_writedata, 0);
        check("arst_addr",  mem_address, 0);
        check("arst_wc",    words_written, 0);
        check("arst_busy",  busy, 0);
        check("arst_ovf",   overflow, 0);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nios_system_2a_sample_packer.md
# nios_system_2a_sample_packer

Upstream write stage for the Nios_System_2A on-chip memory. It accepts a byte stream (valid/ready, end-of-packet) and packs four samples little-endian into each 32-bit word. It writes the packed words through an arbitrated single-port memory interface to a contiguous word range. The Nios processor then consumes the captured buffer through the memory's other slave.

## Interface
- BASE_ADDR, 0, first word address written after `start`
- DEPTH_WORDS, 40000, words in the capture range (must equal memory depth or less)
- ADDR_W, 16, memory word-address width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; arms capture (honoured only in IDLE or HALT)
- stop  in  1  one-cycle pulse; flush and return to IDLE (honoured only in RUN)
- snk_data  in  8  sample byte
- snk_valid  in  1  sample present
- snk_eop  in  1  last sample of packet; forces partial-word write
- snk_ready  out  1  sample accepted when snk_valid & snk_ready
- mem_req  out  1  word buffer holds a word to write
- mem_grant  in  1  memory port granted this cycle
- mem_chipselect, mem_write  out  1  write strobe = wbuf_valid & mem_grant
- mem_address  out  ADDR_W  current write word address
- mem_byteenable  out  4  lanes valid in mem_writedata
- mem_writedata  out  32  packed word
- words_written  out  16  write count since start, saturates at 0xFFFF
- busy  out  1  state != IDLE
- overflow  out  1  sticky: snk_valid seen while HALT; cleared by start

## Operation
- States:
  - IDLE: start → RUN; clears lane, pack mask, words_written, and overflow; sets address to BASE_ADDR.
  - RUN: stop → FLUSH; the last-address write goes to HALT, or wraps when the wrap feature is enabled.
  - FLUSH: goes to IDLE once the pack register and word buffer are both empty.
  - HALT: start → RUN, with the same clears as from IDLE.
- Packing:
  - An accepted sample at lane k (0..3) goes to pack[8k+7:8k], sets mask bit k, and increments lane.
  - The word completes on the lane-3 sample or on an accepted sample with snk_eop.
  - On completion, pack and mask move to the word buffer (wbuf), then lane and mask clear.
  - In FLUSH, a non-empty pack register moves to wbuf as soon as wbuf is empty or draining.
- snk_ready = (state==RUN) & !(wbuf_valid & !mem_grant). This is a combinational path from mem_grant.
- A write occurs in every cycle with wbuf_valid & mem_grant:
  - mem_byteenable = wbuf mask.
  - At the clock edge, wbuf clears unless it is reloaded that same edge, the address increments, and words_written increments.
- Last address (BASE_ADDR+DEPTH_WORDS-1): the write is performed, then the Configuration section applies.
- Simultaneous events:
  - start and stop in the same cycle: only the one legal for the current state acts.
  - stop in the same cycle as an accepted sample: the sample is kept and then flushed.
- reset during operation: all state clears, pending data is discarded, and mem_write drops immediately.

## Timing
- Reset values:
  - snk_ready, mem_req, mem_chipselect, mem_write, busy, overflow: 0.
  - mem_address: BASE_ADDR.
  - mem_byteenable, mem_writedata, words_written: 0.
  - State: IDLE.
- Latency: with the 4th sample accepted at edge N, mem_req is high after edge N, and the write occurs in cycle N+1 if granted.
- With mem_grant held high the block sustains one sample per cycle.
- mem_grant low stalls the sink only while wbuf is full; pack accepts lanes 0..2 meanwhile only if wbuf has room for completion. Otherwise snk_ready is low.
- FLUSH of a partial word takes 1 cycle to move into wbuf plus the grant wait.
- Outputs are registered except mem_write, mem_chipselect, and snk_ready.

## Configuration
- SAMPLE_PACKER_WRAP_EN defined:
  - After the last-address write, the address returns to BASE_ADDR and the block stays in RUN.
  - A sticky `wrapped` output port is added, cleared by start.
- SAMPLE_PACKER_WRAP_EN undefined:
  - After the last-address write the block enters HALT and snk_ready is 0.
  - Any snk_valid in HALT sets overflow.
  - The `wrapped` port does not exist.

## Test plan
- Reset, then start, with grant tied high; send bytes 0x11,0x22,0x33,0x44. Required: one write at address 0 with data 0x44332211, byteenable 0xF, words_written=1.
- Send 0xAA,0xBB with eop on 0xBB. Required: write of 0x0000BBAA (upper bytes don't-care), byteenable 0x3, then lane restarts at 0.
- Hold mem_grant low with wbuf full. Required: snk_ready=0 and no write. Raise grant for one cycle: one write, then snk_ready returns to 1.
- Send 3 bytes, then pulse stop. Required: FLUSH writes byteenable 0x7, then IDLE with busy=0.
- DEPTH_WORDS=4, macro undefined, send 20 bytes. Required: 4 writes at 0..3, HALT, overflow=1. With the macro defined: the 5th write goes to address 0 and wrapped=1.
- Assert reset while wbuf_valid=1. Required: mem_write drops asynchronously and all outputs return to their reset values.
